// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, in-order imem requests, uop buffer towards decode
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  system_stall,
    input  logic                  system_flush,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  source_not_ready,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [INST_WIDTH-1:0] instruction,
    output logic                  uop_valid_out
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // Repeated flushes can stack up more discarded responses than one FIFO's worth.
    localparam int DROP_W = CNT_W + 4;
    localparam logic [INST_WIDTH-1:0] NOP       = INST_WIDTH'(32'h0000_0013);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DROP_W-1:0]     drop_q, drop_d;
    logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      ard_ptr_q, ard_ptr_d, awr_ptr_q, awr_ptr_d;
    logic [ADDR_WIDTH-1:0] buf_pc_q   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc_d   [FIFO_DEPTH];
    logic [INST_WIDTH-1:0] buf_inst_q [FIFO_DEPTH];
    logic [INST_WIDTH-1:0] buf_inst_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] req_addr_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] req_addr_d [FIFO_DEPTH];

    logic [CNT_W-1:0] occupancy, outstanding;
    logic             credit_ok, accept, rsp_drop, rsp_push, rsp_used, pop, not_empty;

    always_comb begin
        occupancy      = wr_ptr_q - rd_ptr_q;
        outstanding    = awr_ptr_q - ard_ptr_q;
        not_empty      = (occupancy != '0);
        credit_ok      = ({1'b0, occupancy} + {1'b0, outstanding}) < (CNT_W + 1)'(FIFO_DEPTH);
        imem_req_valid = reset_n && !system_flush && credit_ok;
        imem_req_addr  = pc_q & WORD_MASK;
        accept         = imem_req_valid && imem_req_ready;
        rsp_drop       = imem_rsp_valid && (drop_q != '0);
        rsp_push       = imem_rsp_valid && (drop_q == '0) && (outstanding != '0);
        rsp_used       = rsp_drop || rsp_push;
        uop_valid_out  = not_empty && !system_flush;
        pop            = uop_valid_out && !system_stall && !source_not_ready;
        pc_out         = not_empty ? buf_pc_q[rd_ptr_q[PTR_W-1:0]] : '0;
        instruction    = not_empty ? buf_inst_q[rd_ptr_q[PTR_W-1:0]] : NOP;
    end

    always_comb begin
        pc_d       = pc_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        ard_ptr_d  = ard_ptr_q;
        awr_ptr_d  = awr_ptr_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        req_addr_d = req_addr_q;
        if (system_flush) begin
            // Everything still in flight, minus the response consumed right now, must be discarded.
            drop_d    = drop_q + DROP_W'(outstanding) - DROP_W'(rsp_used);
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            ard_ptr_d = '0;
            awr_ptr_d = '0;
            if (redirect_valid) begin
                pc_d = redirect_pc & WORD_MASK;
            end
        end else begin
            if (accept) begin
                req_addr_d[awr_ptr_q[PTR_W-1:0]] = imem_req_addr;
                awr_ptr_d = awr_ptr_q + 1'b1;
                pc_d      = pc_q + ADDR_WIDTH'(4);
            end
            if (rsp_drop) begin
                drop_d = drop_q - 1'b1;
            end else if (rsp_push) begin
                buf_pc_d[wr_ptr_q[PTR_W-1:0]]   = req_addr_q[ard_ptr_q[PTR_W-1:0]];
                buf_inst_d[wr_ptr_q[PTR_W-1:0]] = imem_rsp_data;
                wr_ptr_d  = wr_ptr_q + 1'b1;
                ard_ptr_d = ard_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= RESET_PC;
            drop_q    <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            ard_ptr_q <= '0;
            awr_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc_q[i]   <= '0;
                buf_inst_q[i] <= NOP;
                req_addr_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            ard_ptr_q  <= ard_ptr_d;
            awr_ptr_q  <= awr_ptr_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            req_addr_q <= req_addr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - cycle-table bench for fetch_unit with a 1-cycle in-order memory model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        system_stall;
    logic        system_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        source_not_ready;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic        uop_valid_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] memq[$];

    typedef struct {
        logic        stall;
        logic        snr;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic        ready;
        logic        rsp_en;
        logic        e_req_valid;
        logic [31:0] e_addr;
        logic        e_uv;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];

    fetch_unit #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .system_stall    (system_stall),
        .system_flush    (system_flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .source_not_ready(source_not_ready),
        .pc_out          (pc_out),
        .instruction     (instruction),
        .uop_valid_out   (uop_valid_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n && imem_req_valid && imem_req_ready) memq.push_back(imem_req_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mem_step(input logic en);
        logic [31:0] a;
        if (en && memq.size() > 0) begin
            a = memq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = a >> 2;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic add(input logic st, input logic sn, input logic fl, input logic rv,
                       input logic [31:0] rpc, input logic rdy, input logic ren,
                       input logic erv, input logic [31:0] ea, input logic euv,
                       input logic [31:0] epc, input logic [31:0] ei);
        vec_t v;
        v = '{st, sn, fl, rv, rpc, rdy, ren, erv, ea, euv, epc, ei};
        vecs.push_back(v);
    endtask

    initial begin
        // stall snr flush rv rpc ready rsp_en | req_valid addr uop_valid pc_out instruction
        add(0,0,0,0,0,1,1, 1,32'h000, 0,32'h000,32'h13); // 0: first request after reset
        add(0,0,0,0,0,1,1, 1,32'h004, 0,32'h000,32'h13);
        add(0,0,0,0,0,1,1, 0,32'h008, 1,32'h000,32'h00); // 2: first uop
        add(0,0,0,0,0,1,1, 1,32'h008, 1,32'h004,32'h01);
        add(1,0,0,0,0,1,1, 1,32'h00C, 0,32'h000,32'h13); // 4..8: stall
        add(1,0,0,0,0,1,1, 0,32'h010, 1,32'h008,32'h02);
        add(1,0,0,0,0,1,1, 0,32'h010, 1,32'h008,32'h02);
        add(1,0,0,0,0,1,1, 0,32'h010, 1,32'h008,32'h02);
        add(1,0,0,0,0,1,1, 0,32'h010, 1,32'h008,32'h02);
        add(0,0,0,0,0,1,1, 0,32'h010, 1,32'h008,32'h02);
        add(0,0,0,0,0,1,1, 1,32'h010, 1,32'h00C,32'h03);
        add(0,0,0,0,0,1,1, 1,32'h014, 0,32'h000,32'h13);
        add(0,1,0,0,0,1,1, 0,32'h018, 1,32'h010,32'h04); // 12..14: replay hold
        add(0,1,0,0,0,1,1, 0,32'h018, 1,32'h010,32'h04);
        add(0,1,0,0,0,1,1, 0,32'h018, 1,32'h010,32'h04);
        add(0,0,0,0,0,1,1, 0,32'h018, 1,32'h010,32'h04);
        add(0,0,0,0,0,1,1, 1,32'h018, 1,32'h014,32'h05);
        add(0,0,0,0,0,1,0, 1,32'h01C, 0,32'h000,32'h13); // 17..18: memory withholds responses
        add(0,0,1,1,32'h103,1,0, 0,32'h020, 0,32'h000,32'h13); // 18: flush + redirect
        add(0,0,0,0,0,1,1, 1,32'h100, 0,32'h000,32'h13);
        add(0,0,0,0,0,1,1, 1,32'h104, 0,32'h000,32'h13);
        add(0,0,0,0,0,1,1, 0,32'h108, 0,32'h000,32'h13);
        add(0,0,0,0,0,1,1, 0,32'h108, 1,32'h100,32'h40);
        add(0,0,0,0,0,0,1, 1,32'h108, 1,32'h104,32'h41); // 23..26: memory not ready
        add(0,0,0,0,0,0,1, 1,32'h108, 0,32'h000,32'h13);
        add(0,0,0,0,0,0,1, 1,32'h108, 0,32'h000,32'h13);
        add(0,0,0,0,0,0,1, 1,32'h108, 0,32'h000,32'h13);
        add(0,0,0,0,0,1,1, 1,32'h108, 0,32'h000,32'h13);
        add(0,0,0,0,0,1,1, 1,32'h10C, 0,32'h000,32'h13);
        add(1,0,0,0,0,1,1, 0,32'h110, 1,32'h108,32'h42); // 29..30: fill the buffer
        add(1,0,0,0,0,1,1, 0,32'h110, 1,32'h108,32'h42);

        reset_n = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        system_stall = 1'b0;
        system_flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        source_not_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_uop_valid", 32'(uop_valid_out), 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_instruction", instruction, 32'h13);
        reset_n = 1'b1;

        for (int r = 0; r < vecs.size(); r++) begin
            system_stall     = vecs[r].stall;
            source_not_ready = vecs[r].snr;
            system_flush     = vecs[r].flush;
            redirect_valid   = vecs[r].rv;
            redirect_pc      = vecs[r].rpc;
            imem_req_ready   = vecs[r].ready;
            mem_step(vecs[r].rsp_en);
            #1;
            chk($sformatf("row%0d_req_valid", r), 32'(imem_req_valid), 32'(vecs[r].e_req_valid));
            chk($sformatf("row%0d_req_addr", r), imem_req_addr, vecs[r].e_addr);
            chk($sformatf("row%0d_uop_valid", r), 32'(uop_valid_out), 32'(vecs[r].e_uv));
            chk($sformatf("row%0d_pc_out", r), pc_out, vecs[r].e_pc);
            chk($sformatf("row%0d_instruction", r), instruction, vecs[r].e_inst);
            @(negedge clk);
        end

        system_flush = 1'b0;
        redirect_valid = 1'b0;
        mem_step(1'b1);
        #1;
        chk("full_uop_valid", 32'(uop_valid_out), 32'h1);
        chk("full_pc_out", pc_out, 32'h108);
        chk("full_req_valid", 32'(imem_req_valid), 32'h0);
        #2;
        reset_n = 1'b0;
        memq.delete();
        imem_rsp_valid = 1'b0;
        #1;
        chk("async_rst_uop_valid", 32'(uop_valid_out), 32'h0);
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("async_rst_instruction", instruction, 32'h13);
        chk("async_rst_pc_out", pc_out, 32'h0);
        @(negedge clk);
        @(negedge clk);
        system_stall = 1'b0;
        imem_req_ready = 1'b1;
        reset_n = 1'b1;
        #1;
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'h1);
        chk("post_rst_req_addr", imem_req_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_next_addr", imem_req_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; the producer side of the decode stage's input interface (pc_in, instruction, uop_valid_in).
- Keeps the PC and issues in-order word requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions with their PCs in a small FIFO and presents one uop per cycle to decode.
- Honours system_stall, source_not_ready (replay hold), system_flush and branch redirect.

Parameters:
ADDR_WIDTH, 32, PC / memory address width
INST_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, PC loaded at reset
FIFO_DEPTH, 2, instruction buffer entries and maximum in-flight requests (power of 2, ≥2)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_WIDTH  word-aligned fetch address
imem_rsp_valid  in  1  response data valid; responses return in request order
imem_rsp_data  in  INST_WIDTH  fetched instruction
system_stall  in  1  freeze hand-off to decode
system_flush  in  1  discard buffered and in-flight instructions
redirect_valid  in  1  load new PC (ignored unless system_flush=1 in the same cycle)
redirect_pc  in  ADDR_WIDTH  target PC
source_not_ready  in  1  decode replaying; hold the current uop
pc_out  out  ADDR_WIDTH  PC of the presented instruction (to decode pc_in)
instruction  out  INST_WIDTH  presented instruction (to decode instruction)
uop_valid_out  out  1  presented uop valid (to decode uop_valid_in)

Behaviour:

Reset values:
- pc = RESET_PC.
- FIFO empty; outstanding = 0; drop = 0.
- imem_req_valid = 0, uop_valid_out = 0, pc_out = 0, instruction = 32'h0000_0013 (NOP).

Request issue:
- imem_req_valid = !system_flush && (outstanding + occupancy < FIFO_DEPTH).
- imem_req_addr = pc with bits [1:0] forced to 0.
- Accept is imem_req_valid && imem_req_ready. On accept: pc <= pc + 4 (wraps modulo 2^ADDR_WIDTH) and outstanding increments.
- While imem_req_valid=1 and imem_req_ready=0, imem_req_addr is held stable.

Response handling:
- If drop > 0: decrement drop and discard the data.
- Else if outstanding > 0: push {pc, data} into the FIFO and decrement outstanding.
- Else the response is spurious and is ignored; no state changes.
- The credit rule guarantees the FIFO cannot overflow.
- The entry PC comes from a request-address FIFO of depth FIFO_DEPTH that is pushed on accept.

Presentation:
- uop_valid_out = FIFO non-empty.
- pc_out and instruction come combinationally from the FIFO head; when empty they show 0 and NOP.
- Pop when uop_valid_out && !system_stall && !source_not_ready.
- While source_not_ready=1, the head is held stable for at least one full cycle so decode re-decodes the same instruction.
- Zero-latency bypass is not provided: response-to-uop_valid_out latency is 1 cycle.
- Push and pop in the same cycle is allowed; occupancy is unchanged.

Flush (system_flush=1, evaluated at the clock edge):
- FIFO and request-address FIFO are cleared.
- drop <= outstanding + (accept this cycle ? 1 : 0) − (response this cycle ? 1 : 0, if it was to be dropped or pushed).
- outstanding <= 0.
- pc <= redirect_valid ? {redirect_pc[ADDR_WIDTH-1:2], 2'b00} : pc.
- imem_req_valid is 0 in the flush cycle, so there is no accept.
- uop_valid_out is forced to 0 in the flush cycle.
- Fetching resumes the next cycle from the new pc.
- Back-to-back flushes are legal; drop accumulates the count correctly.

Precedence: reset_n > system_flush > response/issue/pop.

Reset asserted mid-operation: all state returns to reset values immediately. Responses to in-flight requests are the memory's responsibility; memory must also be reset.

Test Plan:
- Reset release, memory always ready with 1-cycle response latency returning addr>>2 as data → requests to 0x0, 0x4, 0x8…; uop_valid_out first high 2 cycles after the first accept; pc_out/instruction pairs (0x0,0x0), (0x4,0x1), (0x8,0x2) on consecutive cycles.
- Hold system_stall=1 for 5 cycles → FIFO fills to 2; imem_req_valid drops to 0 with 0 outstanding; head pc_out=0x8 stays constant. Release → 0x8 and then 0xC issue in order with no loss or duplicate.
- Pulse source_not_ready=1 for 3 cycles while head is (0x10, I) → the same pc_out/instruction is held all 3 cycles; the pop happens on the first cycle after deassertion.
- 2 requests in flight, pulse system_flush with redirect_valid=1, redirect_pc=0x103 → the next 2 responses are discarded; the next request address is 0x100; the first uop after the flush has pc_out=0x100.
- imem_req_ready=0 for 4 cycles with pc=0x20 → imem_req_addr stays 0x20; pc advances only on the accept cycle.
- Assert reset_n=0 asynchronously mid-stream while FIFO is full → uop_valid_out=0, imem_req_valid=0 and instruction=NOP immediately, without waiting for a clock; after release the first request is to RESET_PC.
